// File: rtl/dma_pkg.sv
// Shared types and defaults for the multi-burst DMA engine: FSM state encoding,
// default parameter values and the minimum-one-bit clog2 helper.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        NEXT = 2'd3
    } dma_state_t;

    localparam int DEF_WORD_SIZE   = 16;
    localparam int DEF_BURST_WORDS = 4;
    localparam int DEF_MAX_BURSTS  = 4;
    localparam int DEF_WRITE_LAT   = 4;

    // Index width for a counter over n values; never narrower than one bit.
    function automatic int off_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dma_bus_drv.sv
// Bus-side register stage of the DMA engine: holds the burst address and the
// captured device data, and releases WRITE/addr/data to Z when the bus is not owned.
import dma_pkg::*;

module dma_bus_drv #(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int BURST_WORDS = DEF_BURST_WORDS
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            own,
    input  logic                            write_pulse,
    input  logic                            load_addr,
    input  logic [WORD_SIZE-1:0]            addr_in,
    input  logic                            load_data,
    input  logic [BURST_WORDS*WORD_SIZE-1:0] data_in,
    output logic                            WRITE,
    output logic [WORD_SIZE-1:0]            addr,
    output logic [BURST_WORDS*WORD_SIZE-1:0] data
);

    localparam int DATA_W = BURST_WORDS * WORD_SIZE;

    logic [WORD_SIZE-1:0] addr_reg;
    logic [WORD_SIZE-1:0] word_reg [BURST_WORDS];
    wire  [DATA_W-1:0]    data_flat;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            addr_reg <= '0;
        end else if (load_addr) begin
            addr_reg <= addr_in;
        end
    end

    // One register per word keeps the capture path word-sliced.
    generate
        for (genvar gi = 0; gi < BURST_WORDS; gi++) begin : g_word
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    word_reg[gi] <= '0;
                end else if (load_data) begin
                    word_reg[gi] <= data_in[gi*WORD_SIZE +: WORD_SIZE];
                end
            end
            assign data_flat[gi*WORD_SIZE +: WORD_SIZE] = word_reg[gi];
        end
    endgenerate

    assign WRITE = own ? write_pulse : 1'bz;
    assign addr  = own ? addr_reg    : {WORD_SIZE{1'bz}};
    assign data  = own ? data_flat   : {DATA_W{1'bz}};

endmodule

// File: rtl/dma_engine.sv
// Multi-burst DMA controller moving device bursts into memory over a BR/BG-arbitrated bus.
// Optional DMA_CYCLE_STEAL_EN releases the bus between bursts instead of holding it.
import dma_pkg::*;

module dma_engine #(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int BURST_WORDS = DEF_BURST_WORDS,
    parameter int MAX_BURSTS  = DEF_MAX_BURSTS,
    parameter int WRITE_LAT   = DEF_WRITE_LAT,
    localparam int OFF_W      = off_w(MAX_BURSTS),
    localparam int DATA_W     = BURST_WORDS * WORD_SIZE
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WORD_SIZE-1:0] cmd_addr,
    input  logic [OFF_W:0]       cmd_len,
    input  logic                 BG,
    output logic                 BR,
    input  logic [DATA_W-1:0]    edata,
    output logic [OFF_W-1:0]     offset,
    output logic                 WRITE,
    output logic [WORD_SIZE-1:0] addr,
    output logic [DATA_W-1:0]    data,
    output logic                 interrupt,
    input  logic                 int_ack
);

    localparam int LEN_W = OFF_W + 1;
    localparam int CW    = off_w(WRITE_LAT);
    localparam logic [LEN_W-1:0]     MAX_LEN  = LEN_W'(MAX_BURSTS);
    localparam logic [CW-1:0]        LAST_C   = CW'(WRITE_LAT - 1);
    localparam logic [WORD_SIZE-1:0] BW_STEP  = WORD_SIZE'(BURST_WORDS);

    dma_state_t           state_reg, state_next;
    logic [WORD_SIZE-1:0] base_reg, base_next;
    logic [LEN_W-1:0]     len_reg, len_next;
    logic [LEN_W-1:0]     b_reg, b_next;
    logic [CW-1:0]        c_reg, c_next;
    logic [OFF_W-1:0]     offset_reg, offset_next;
    logic                 br_reg, br_next;
    logic                 int_reg, int_next;

    logic                 int_set;
    logic                 load_addr;
    logic                 load_data;
    logic                 cmd_ok;
    logic                 own;
    logic                 write_pulse;
    logic [LEN_W-1:0]     b_inc;
    logic [WORD_SIZE-1:0] addr_in;

    assign cmd_ready   = (state_reg == IDLE) && !int_reg;
    assign cmd_ok      = (cmd_len != '0) && (cmd_len <= MAX_LEN);
    assign own         = br_reg & BG;
    assign write_pulse = (state_reg == XFER) && (c_reg == '0);
    assign b_inc       = b_reg + LEN_W'(1);

    // Address is computed from the burst index that will be current in XFER.
    assign addr_in = base_reg + WORD_SIZE'(b_next) * BW_STEP;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= IDLE;
            base_reg   <= '0;
            len_reg    <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            offset_reg <= '0;
            br_reg     <= 1'b0;
            int_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            base_reg   <= base_next;
            len_reg    <= len_next;
            b_reg      <= b_next;
            c_reg      <= c_next;
            offset_reg <= offset_next;
            br_reg     <= br_next;
            int_reg    <= int_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        base_next   = base_reg;
        len_next    = len_reg;
        b_next      = b_reg;
        c_next      = c_reg;
        offset_next = offset_reg;
        br_next     = br_reg;
        int_set     = 1'b0;
        load_addr   = 1'b0;
        load_data   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_valid && cmd_ready && cmd_ok) begin
                    base_next   = cmd_addr;
                    len_next    = cmd_len;
                    b_next      = '0;
                    c_next      = '0;
                    offset_next = '0;
                    br_next     = 1'b1;
                    state_next  = REQ;
                end
            end
            REQ: begin
                br_next = 1'b1;
                // Only a grant seen while our request is already visible counts.
                if (br_reg && BG) begin
                    c_next     = '0;
                    load_addr  = 1'b1;
                    state_next = XFER;
                end
            end
            XFER: begin
                if (!BG) begin
                    // Preempted: the whole burst is replayed once the grant returns.
                    c_next     = '0;
                    state_next = REQ;
                end else begin
                    if (c_reg == '0) begin
                        load_data = 1'b1;
                    end
                    if (c_reg == LAST_C) begin
                        state_next = NEXT;
                    end else begin
                        c_next = c_reg + CW'(1);
                    end
                end
            end
            NEXT: begin
                b_next      = b_inc;
                offset_next = b_inc[OFF_W-1:0];
                c_next      = '0;
                if (b_inc == len_reg) begin
                    br_next    = 1'b0;
                    int_set    = 1'b1;
                    state_next = IDLE;
                end else begin
`ifdef DMA_CYCLE_STEAL_EN
                    br_next    = 1'b0;
                    state_next = REQ;
`else
                    load_addr  = 1'b1;
                    state_next = XFER;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        int_next = int_reg;
        if (int_set) begin
            int_next = 1'b1;
        end else if (int_ack) begin
            int_next = 1'b0;
        end
    end

    assign BR        = br_reg;
    assign interrupt = int_reg;
    assign offset    = offset_reg;

    dma_bus_drv #(
        .WORD_SIZE   (WORD_SIZE),
        .BURST_WORDS (BURST_WORDS)
    ) u_bus_drv (
        .CLK         (CLK),
        .RESET       (RESET),
        .own         (own),
        .write_pulse (write_pulse),
        .load_addr   (load_addr),
        .addr_in     (addr_in),
        .load_data   (load_data),
        .data_in     (edata),
        .WRITE       (WRITE),
        .addr        (addr),
        .data        (data)
    );

endmodule

// File: tb/tb_dma_engine.sv
// Directed self-checking bench for dma_engine with default parameters; the CPU side
// grants the bus the cycle BR is seen high and can withhold the grant to preempt.
module tb_dma_engine;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        cmd_valid;
    logic [15:0] cmd_addr;
    logic [2:0]  cmd_len;
    logic        BG;
    logic [63:0] edata;
    logic        int_ack;
    wire         cmd_ready;
    wire         BR;
    wire  [1:0]  offset;
    wire         WRITE;
    wire  [15:0] addr;
    wire  [63:0] data;
    wire         interrupt;

    int errors = 0;
    int checks = 0;
    int block_cnt = 0;
    int br_low = 0;
    logic [15:0] wr_addr [$];
    logic [1:0]  wr_off  [$];

    bit done;
    int first_idx;
    int ncyc;
    int nwr;

    always #5 CLK = ~CLK;

    dma_engine dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .BG        (BG),
        .BR        (BR),
        .edata     (edata),
        .offset    (offset),
        .WRITE     (WRITE),
        .addr      (addr),
        .data      (data),
        .interrupt (interrupt),
        .int_ack   (int_ack)
    );

    function automatic logic [63:0] pat(input logic [1:0] off);
        logic [15:0] o;
        o = {10'd0, off, 4'd0};
        return {16'hD003 + o, 16'hD002 + o, 16'hD001 + o, 16'hD000 + o};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (block_cnt > 0) begin
            BG = 1'b0;
            block_cnt--;
        end else begin
            BG = (BR === 1'b1);
        end
        edata = pat(offset);
    endtask

    task automatic issue(input logic [15:0] a, input logic [2:0] l);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        $display("cmd addr=%h len=%0d ready_after=%0b BR=%0b", a, l, cmd_ready, BR);
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("ack_int_clear", {63'd0, interrupt}, 64'd0);
        chk("ack_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    endtask

    // Watches one transfer until interrupt; logs every WRITE and checks captured data.
    task automatic run_xfer(input int budget, input bit preempt,
                            output bit fin, output int first, output int cyc);
        int   since;
        bit   pend;
        bit   fired;
        logic [1:0] pend_off;
        int   n;
        since = -1; pend = 0; fired = 0; pend_off = '0; n = 0;
        fin = 0; first = -1; cyc = -1;
        wr_addr.delete();
        wr_off.delete();
        br_low = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (pend) begin
                chk("burst_data", data, pat(pend_off));
                pend = 0;
            end
            if (WRITE === 1'b1) begin
                wr_addr.push_back(addr);
                wr_off.push_back(offset);
                $display("write addr=%h offset=%0d cycle=%0d", addr, offset, i);
                if (first < 0) first = i;
                pend = 1;
                pend_off = offset;
                n++;
                since = 0;
            end else if (since >= 0) begin
                since++;
            end
            if (preempt && !fired && n == 2 && since == 2) begin
                BG = 1'b0;
                block_cnt = 4;
                fired = 1;
            end
            if (n > 0 && BR !== 1'b1 && interrupt !== 1'b1) br_low++;
            if (interrupt === 1'b1) begin
                fin = 1;
                cyc = i;
                chk("br_low_with_int", {63'd0, BR}, 64'd0);
                break;
            end
        end
    endtask

    initial begin
        RESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        BG = 1'b0; edata = '0; int_ack = 1'b0;
        tick();
        tick();
        chk("rst_br", {63'd0, BR}, 64'd0);
        chk("rst_int", {63'd0, interrupt}, 64'd0);
        chk("rst_offset", {62'd0, offset}, 64'd0);
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_write_off", {63'd0, (WRITE === 1'b1)}, 64'd0);
        RESET = 1'b0;
        tick();

        // Three bursts from 0x01F4
        issue(16'h01F4, 3'd3);
        chk("t1_br_rise", {63'd0, BR}, 64'd1);
        run_xfer(60, 1'b0, done, first_idx, ncyc);
        chk("t1_done", {63'd0, done}, 64'd1);
        chk("t1_first_write", 64'(first_idx), 64'd0);
        chk("t1_nwrites", 64'(wr_addr.size()), 64'd3);
        chk("t1_addr0", {48'd0, wr_addr[0]}, 64'h01F4);
        chk("t1_addr1", {48'd0, wr_addr[1]}, 64'h01F8);
        chk("t1_addr2", {48'd0, wr_addr[2]}, 64'h01FC);
        chk("t1_off0", {62'd0, wr_off[0]}, 64'd0);
        chk("t1_off1", {62'd0, wr_off[1]}, 64'd1);
        chk("t1_off2", {62'd0, wr_off[2]}, 64'd2);
`ifdef DMA_CYCLE_STEAL_EN
        chk("t1_br_gaps", {63'd0, (br_low >= 2)}, 64'd1);
        chk("t1_cycles", 64'(ncyc), 64'd19);
`else
        chk("t1_br_gaps", 64'(br_low), 64'd0);
        chk("t1_cycles", 64'(ncyc), 64'd15);
`endif

        // Interrupt is sticky and blocks new commands until acknowledged
        cmd_addr = 16'h0400; cmd_len = 3'd1; cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0 || i == 9) begin
                chk("t2_int_sticky", {63'd0, interrupt}, 64'd1);
                chk("t2_cmd_refused", {63'd0, cmd_ready}, 64'd0);
            end
        end
        cmd_valid = 1'b0;
        chk("t2_no_accept_br", {63'd0, BR}, 64'd0);
        ack();

        // Preempt burst 1 at c=2 for five cycles
        issue(16'h01F4, 3'd3);
        run_xfer(80, 1'b1, done, first_idx, ncyc);
        chk("t3_done", {63'd0, done}, 64'd1);
        chk("t3_nwrites", 64'(wr_addr.size()), 64'd4);
        chk("t3_addr0", {48'd0, wr_addr[0]}, 64'h01F4);
        chk("t3_addr1", {48'd0, wr_addr[1]}, 64'h01F8);
        chk("t3_addr2", {48'd0, wr_addr[2]}, 64'h01F8);
        chk("t3_addr3", {48'd0, wr_addr[3]}, 64'h01FC);
        chk("t3_off2", {62'd0, wr_off[2]}, 64'd1);
        chk("t3_off3", {62'd0, wr_off[3]}, 64'd2);
        ack();

        // Address wrap at the top of the address space
        issue(16'hFFFC, 3'd2);
        run_xfer(60, 1'b0, done, first_idx, ncyc);
        chk("t4_done", {63'd0, done}, 64'd1);
        chk("t4_nwrites", 64'(wr_addr.size()), 64'd2);
        chk("t4_addr0", {48'd0, wr_addr[0]}, 64'hFFFC);
        chk("t4_addr1", {48'd0, wr_addr[1]}, 64'h0000);
        ack();

        // Illegal lengths are ignored
        issue(16'h0100, 3'd0);
        chk("t5_len0_br", {63'd0, BR}, 64'd0);
        chk("t5_len0_ready", {63'd0, cmd_ready}, 64'd1);
        issue(16'h0100, 3'd5);
        tick();
        chk("t5_len5_br", {63'd0, BR}, 64'd0);
        chk("t5_len5_ready", {63'd0, cmd_ready}, 64'd1);

        // Reset in the middle of burst 1
        issue(16'h01F4, 3'd3);
        nwr = 0;
        for (int i = 0; i < 40 && nwr < 2; i++) begin
            tick();
            if (WRITE === 1'b1) nwr++;
        end
        chk("t6_reached_burst1", 64'(nwr), 64'd2);
        tick();
        RESET = 1'b1;
        tick();
        chk("t6_rst_br", {63'd0, BR}, 64'd0);
        chk("t6_rst_offset", {62'd0, offset}, 64'd0);
        chk("t6_rst_int", {63'd0, interrupt}, 64'd0);
        chk("t6_rst_write_off", {63'd0, (WRITE === 1'b1)}, 64'd0);
        chk("t6_rst_ready", {63'd0, cmd_ready}, 64'd1);
        RESET = 1'b0;
        nwr = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (WRITE === 1'b1 || interrupt === 1'b1) nwr++;
        end
        chk("t6_quiet_after_rst", 64'(nwr), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
